sysbus_mem_responder: RTL

Memory-side responder for the Sysbus cache-line protocol: accepts line-granular read and write requests from an initiator (core fetch unit, future data cache), services them from an internal line-addressed array after a fixed access latency, and streams read data back as eight 64-bit beats. Sits on the far end of Sysbus as the simulation memory model and as the template for the eventual DRAM-controller front end.

---
 rtl/sysbus_pkg.sv | 31 +++
 rtl/sysbus_mem_array.sv | 36 +++
 rtl/sysbus_mem_responder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sysbus_pkg.sv
// Shared Sysbus definitions: request tag layout, rw/type encodings, line geometry
// and the memory responder state encoding.
package sysbus_pkg;

    localparam int unsigned LINE_BYTES     = 64;
    localparam int unsigned BEATS_PER_LINE = 8;
    localparam int unsigned WORD_W         = 64;
    localparam int unsigned BEAT_W         = $clog2(BEATS_PER_LINE);
    localparam int unsigned TAG_W          = 13;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic [3:0] TYPE_MEMORY = 4'h0;
    localparam logic [3:0] TYPE_MMIO   = 4'h1;

    typedef struct packed {
        logic       rw;
        logic [3:0] kind;
        logic [7:0] id;
    } sysbus_tag_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_ACK,
        ST_WAIT,
        ST_RD_BEAT,
        ST_WR_BEAT
    } mem_state_e;

endpackage

// File: rtl/sysbus_mem_array.sv
// Line-organised backing store: DEPTH lines x 8 words x 64 bits, one registered
// read port and one word write port.
module sysbus_mem_array
    import sysbus_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned LINE_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [LINE_W-1:0] rd_line,
    input  logic [BEAT_W-1:0] rd_word,
    output logic [WORD_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [LINE_W-1:0] wr_line,
    input  logic [BEAT_W-1:0] wr_word,
    input  logic [WORD_W-1:0] wr_data
);

    // NOTE: the storage array has no reset; clearing thousands of words would
    // forbid RAM inference. The declaration initialiser only zeroes it at time 0.
    logic [WORD_W-1:0] mem_q [DEPTH*BEATS_PER_LINE] = '{default: '0};
    logic [WORD_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[{wr_line, wr_word}] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[{rd_line, rd_word}];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory-side responder: line reads streamed as 8 beats after LATENCY,
// line writes absorbed as 8 beats. Optional: SYSBUS_MEM_CRITICAL_WORD_FIRST_EN.
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reqcyc,
    input  logic [WORD_W-1:0] req,
    input  logic [TAG_W-1:0]  reqtag,
    output logic              reqack,
    output logic              respcyc,
    output logic [WORD_W-1:0] resp,
    output logic [TAG_W-1:0]  resptag,
    input  logic              respack
);

    localparam int unsigned LINE_W = $clog2(DEPTH);
    localparam int unsigned OFFS_W = $clog2(LINE_BYTES);
    localparam int unsigned CNT_W  = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    // HDR_ACK already supplies one latency cycle, so WAIT lasts LATENCY-1 cycles.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_LINE - 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [BEAT_W-1:0] start_q, start_d;
    logic [LINE_W-1:0] line_q, line_d;
    sysbus_tag_t       tag_q, tag_d;

    sysbus_tag_t       hdr_tag;
    logic [LINE_W-1:0] hdr_line;
    logic [BEAT_W-1:0] hdr_start;

    logic              rd_en, wr_en;
    logic [LINE_W-1:0] rd_line;
    logic [BEAT_W-1:0] rd_word, wr_word;
    logic [WORD_W-1:0] rd_data;

    assign hdr_tag  = sysbus_tag_t'(reqtag);
    assign hdr_line = req[OFFS_W +: LINE_W];
`ifdef SYSBUS_MEM_CRITICAL_WORD_FIRST_EN
    assign hdr_start = req[OFFS_W-1 -: BEAT_W];
`else
    assign hdr_start = '0;
`endif

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        start_d = start_q;
        line_d  = line_q;
        tag_d   = tag_q;
        rd_en   = 1'b0;
        rd_line = line_q;
        rd_word = start_q + beat_q;
        wr_en   = 1'b0;
        wr_word = start_q + beat_q;

        unique case (state_q)
            ST_IDLE: begin
                if (reqcyc) state_d = ST_HDR_ACK;
            end
            ST_HDR_ACK: begin
                // Read straight from the header so LATENCY=1 still has data ready.
                rd_en   = 1'b1;
                rd_line = hdr_line;
                rd_word = hdr_start;
                if (reqcyc) begin
                    line_d  = hdr_line;
                    start_d = hdr_start;
                    tag_d   = hdr_tag;
                    beat_d  = '0;
                    cnt_d   = CNT_LOAD;
                    if (hdr_tag.rw == RW_READ) begin
                        state_d = (LATENCY == 1) ? ST_RD_BEAT : ST_WAIT;
                    end else begin
                        state_d = ST_WR_BEAT;
                    end
                end
            end
            ST_WAIT: begin
                rd_en = 1'b1;
                if (cnt_q == '0) state_d = ST_RD_BEAT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_RD_BEAT: begin
                if (respack) begin
                    rd_en   = 1'b1;
                    rd_word = start_q + beat_q + 1'b1;
                    beat_d  = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) state_d = ST_IDLE;
                end
            end
            ST_WR_BEAT: begin
                if (reqcyc) begin
                    wr_en  = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            start_q <= '0;
            line_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            start_q <= start_d;
            line_q  <= line_d;
            tag_q   <= tag_d;
        end
    end

    sysbus_mem_array #(
        .DEPTH  (DEPTH),
        .LINE_W (LINE_W)
    ) u_array (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_line (rd_line),
        .rd_word (rd_word),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_line (line_q),
        .wr_word (wr_word),
        .wr_data (req)
    );

    assign reqack  = (state_q == ST_HDR_ACK) || (state_q == ST_WR_BEAT);
    assign respcyc = (state_q == ST_RD_BEAT);
    // Gated so the output reads zero whenever no beat is presented, including in reset.
    assign resp    = respcyc ? rd_data : '0;
    assign resptag = tag_q;

endmodule
